colour_seq_player: RTL

// Parametrised successor to the 4-colour one-hot encoder. Stores a sequence of

---
 rtl/colour_seq_player.sv | 139 +++++++++++++
 1 files changed

// File: rtl/colour_seq_player.sv
// Colour sequence recorder and player for the memory-game lamps.
// Appends codes via valid/ready, replays them as one-hot on/off pulses.
module colour_seq_player #(
  parameter int COLOUR_W   = 2,
  parameter int DEPTH      = 16,
  parameter int ON_CYCLES  = 1000,
  parameter int OFF_CYCLES = 250,
  parameter int TMR_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       oe,
  input  logic                       in_valid,
  input  logic [COLOUR_W-1:0]        in_colour,
  output logic                       in_ready,
  input  logic                       clear,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH):0]     seq_len,
  output logic [(2**COLOUR_W)-1:0]   colour_out
);

  localparam int NC = 2**COLOUR_W;
  localparam int IW = $clog2(DEPTH);
  localparam int LW = IW + 1;

  localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0] OFF_LOAD = TMR_W'(OFF_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF
  } state_t;

  state_t              state;
  logic [COLOUR_W-1:0] mem [DEPTH];
  logic [IW-1:0]       idx;
  logic [TMR_W-1:0]    timer;
  logic [NC-1:0]       lamp;

  logic full;
  logic wr_en;
  logic last;

  function automatic logic [NC-1:0] onehot(
    input logic [COLOUR_W-1:0] c
  );
    logic [NC-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  assign full     = (seq_len == LW'(DEPTH));
  assign in_ready = (state == S_IDLE) & ~full & ~clear;
  // start outranks an append in the same cycle
  assign wr_en    = in_valid & in_ready & ~start;
  assign last     = ((LW'(idx) + LW'(1)) >= seq_len);
  assign busy     = (state != S_IDLE);
  // oe only masks the lamp; playback timing is unaffected
  assign colour_out = oe ? lamp : '0;

  // sequence storage, written at the current tail
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem[seq_len[IW-1:0]] <= in_colour;
    end
  end

  // playback FSM with registered lamp and done pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      seq_len <= '0;
      idx     <= '0;
      timer   <= '0;
      lamp    <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        state   <= S_IDLE;
        seq_len <= '0;
        idx     <= '0;
        timer   <= '0;
        lamp    <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              if (seq_len != '0) begin
                state <= S_ON;
                idx   <= '0;
                timer <= ON_LOAD;
                lamp  <= onehot(mem[0]);
              end else begin
                done <= 1'b1;
              end
            end else if (wr_en) begin
              seq_len <= seq_len + 1'b1;
            end
          end
          S_ON: begin
            if (timer == '0) begin
              state <= S_OFF;
              timer <= OFF_LOAD;
              lamp  <= '0;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          S_OFF: begin
            if (timer == '0) begin
              if (!last) begin
                idx   <= idx + 1'b1;
                state <= S_ON;
                timer <= ON_LOAD;
                lamp  <= onehot(mem[idx + 1'b1]);
              end else begin
                state <= S_IDLE;
                idx   <= '0;
                done  <= 1'b1;
              end
            end else begin
              timer <= timer - 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            lamp  <= '0;
          end
        endcase
      end
    end
  end

endmodule
